// File: rtl/audio_framer_f256.sv
// Overlapping frame generator: buffers a sample stream in a circular RAM and replays
// N-sample frames every HOP samples over a valid/ready stream with a last marker.
module audio_framer_f256 #(
    parameter int N   = 256,
    parameter int HOP = 128,
    parameter int DW  = 32
) (
    input  logic          hclk,
    input  logic          rst_n,
    input  logic          sync_clr,
    input  logic [DW-1:0] data_in,
    input  logic          valid_in,
    output logic          ready_out,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    output logic          last,
    input  logic          ready_in
);
    localparam int            AW       = $clog2(N);
    localparam logic [AW-1:0] HOP_P    = AW'(HOP);
    localparam logic [AW:0]   HOP_A    = (AW+1)'(HOP);
    localparam logic [AW:0]   FULL_M1  = (AW+1)'(N - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    // Handshakes: a word moves on any rising edge where its valid and ready are both high;
    // valid_out, data_out and last hold steady until that edge, ready never waits on valid.
    typedef enum logic [1:0] {FILL, LOAD, SEND} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] base_ptr_q, base_ptr_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [AW:0]   avail_q, avail_d;
    logic          ready_out_q, ready_out_d;
    logic          valid_out_q, valid_out_d;
    logic          last_q, last_d;
    logic [DW-1:0] data_out_q, data_out_d;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] rd_data_q;
    logic          wr_en, rd_en;
    logic [AW-1:0] rd_addr;
    logic          in_xfer, out_xfer;

    assign in_xfer  = valid_in && ready_out_q;
    assign out_xfer = valid_out_q && ready_in;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        base_ptr_d  = base_ptr_q;
        rd_cnt_d    = rd_cnt_q;
        avail_d     = avail_q;
        ready_out_d = ready_out_q;
        valid_out_d = valid_out_q;
        last_d      = last_q;
        data_out_d  = data_out_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = base_ptr_q;
        if (sync_clr) begin
            state_d     = FILL;
            wr_ptr_d    = '0;
            base_ptr_d  = '0;
            rd_cnt_d    = '0;
            avail_d     = '0;
            ready_out_d = 1'b1;
            valid_out_d = 1'b0;
            last_d      = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    ready_out_d = 1'b1;
                    if (in_xfer) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        avail_d  = avail_q + (AW+1)'(1);
                        if (avail_q == FULL_M1) begin
                            state_d     = LOAD;
                            ready_out_d = 1'b0;
                        end
                    end
                end
                LOAD: begin
                    rd_en       = 1'b1;
                    rd_addr     = base_ptr_q;
                    state_d     = SEND;
                    ready_out_d = 1'b0;
                end
                SEND: begin
                    ready_out_d = 1'b0;
                    if (!valid_out_q) begin
                        // Present sample 0 and prefetch sample 1 so transfers run back to back.
                        data_out_d  = rd_data_q;
                        valid_out_d = 1'b1;
                        last_d      = 1'b0;
                        rd_en       = 1'b1;
                        rd_addr     = base_ptr_q + AW'(1);
                    end else if (out_xfer) begin
                        if (last_q) begin
                            valid_out_d = 1'b0;
                            last_d      = 1'b0;
                            rd_cnt_d    = '0;
                            base_ptr_d  = base_ptr_q + HOP_P;
                            avail_d     = avail_q - HOP_A;
                            state_d     = FILL;
                            ready_out_d = 1'b1;
                        end else begin
                            data_out_d = rd_data_q;
                            rd_cnt_d   = rd_cnt_q + AW'(1);
                            last_d     = ((rd_cnt_q + AW'(1)) == LAST_IDX);
                            rd_en      = 1'b1;
                            rd_addr    = base_ptr_q + rd_cnt_q + AW'(2);
                        end
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            base_ptr_q  <= '0;
            rd_cnt_q    <= '0;
            avail_q     <= '0;
            ready_out_q <= 1'b0;
            valid_out_q <= 1'b0;
            last_q      <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            base_ptr_q  <= base_ptr_d;
            rd_cnt_q    <= rd_cnt_d;
            avail_q     <= avail_d;
            ready_out_q <= ready_out_d;
            valid_out_q <= valid_out_d;
            last_q      <= last_d;
            data_out_q  <= data_out_d;
        end
    end

    // Sample RAM with a registered read port; contents need no reset.
    always_ff @(posedge hclk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data_in;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign ready_out = ready_out_q;
    assign valid_out = valid_out_q;
    assign last      = last_q;
    assign data_out  = data_out_q;

endmodule
